// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity, stop bits and bit period, LSB first.
// Define UART_TX_FIFO_EN to put a 4-entry word FIFO in front of the shifter.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_full
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_chk_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_chk_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;

    logic                 load;
    logic [DATA_BITS-1:0] load_word;
    logic                 par_calc;
    logic                 bit_end;
    logic                 frame_end;
    logic                 active_next;
    logic                 busy_next;
    logic                 full_next;

    // Frame timing decode shared by the FSM and the word source.
    always_comb begin
        bit_end     = (bit_cnt == CNT_LAST);
        frame_end   = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
        active_next = load || ((state != S_IDLE) && !frame_end);
        par_calc    = (PARITY == 1) ? ~^load_word : ^load_word;
    end

`ifdef UART_TX_FIFO_EN
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned FCNT_W     = 3;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [FCNT_W-1:0]    fifo_cnt;
    logic [FCNT_W-1:0]    fifo_cnt_next;
    logic                 push;
    logic                 pop;

    // Pop whenever the shifter is free, including the final stop edge, so frames run gapless.
    always_comb begin
        push          = start && !tx_full;
        pop           = (fifo_cnt != '0) && ((state == S_IDLE) || frame_end);
        fifo_cnt_next = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
        load          = pop;
        load_word     = fifo_mem[rd_ptr];
        busy_next     = active_next || (fifo_cnt_next != '0);
        full_next     = (fifo_cnt_next == FCNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt_next;
        end
    end
`else
    // Without the FIFO a start is only taken while the line is idle; full simply tracks busy.
    always_comb begin
        load      = (state == S_IDLE) && start && !tx_full;
        load_word = tx_data;
        busy_next = active_next;
        full_next = active_next;
    end
`endif

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            tx_full <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_busy <= busy_next;
            tx_full <= full_next;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (load) begin
                        state   <= S_START;
                        tx      <= 1'b0;
                        bit_cnt <= '0;
                        shreg   <= load_word;
                        par_q   <= par_calc;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        tx      <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx    <= par_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            tx_done <= 1'b1;
                            if (load) begin
                                state <= S_START;
                                tx    <= 1'b0;
                                shreg <= load_word;
                                par_q <= par_calc;
                            end else begin
                                state <= S_IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
